// File: rtl/l1_cache_responder_if.sv
// rtl/l1_cache_responder_if.sv - CPU request bus and L2 line bus of the L1 cache responder
interface l1_cache_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // master: CPU plus lower memory level, i.e. everything around the cache
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l1_cache_responder.sv
// rtl/l1_cache_responder.sv - direct-mapped write-back write-allocate L1 cache with hit/miss counters
module l1_cache_responder #(
    parameter int NUM_SETS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_cache_responder_if.slave  bus,
    input  logic                 flush_hit,
    input  logic                 flush_miss,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int S  = $clog2(NUM_SETS);
    localparam int TW = 27 - S;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
    state_t state, state_next;

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TW-1:0]       tag_arr  [NUM_SETS];
    logic [255:0]        data_arr [NUM_SETS];

    logic [S-1:0]  idx;
    logic [TW-1:0] req_tag;
    logic [2:0]    word;
    logic [7:0]    word_lsb;
    logic          req;
    logic          hit;
    logic [31:0]   cur_word;
    logic [31:0]   merged_word;
    logic          hit_fire;
    logic          write_fire;
    logic          fill_fire;
    logic          miss_fire;
    logic [1:0]    unused_addr_bits;

    assign idx              = bus.mem_address[4+S:5];
    assign req_tag          = bus.mem_address[31:5+S];
    assign word             = bus.mem_address[4:2];
    assign word_lsb         = {word, 5'd0};
    assign unused_addr_bits = bus.mem_address[1:0];
    assign req              = bus.mem_read | bus.mem_write;
    assign hit              = valid[idx] && (tag_arr[idx] == req_tag);
    assign cur_word         = data_arr[idx][word_lsb +: 32];

    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_byte_enable[i]) begin
                merged_word[i*8 +: 8] = bus.mem_wdata[i*8 +: 8];
            end
        end
    end

    // Request fields are used live: the CPU holds them stable until mem_resp.
    always_comb begin
        state_next       = state;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        hit_fire         = 1'b0;
        write_fire       = 1'b0;
        fill_fire        = 1'b0;
        miss_fire        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = cur_word;
                    hit_fire      = 1'b1;
                    write_fire    = bus.mem_write;
                    state_next    = IDLE;
                end else begin
                    miss_fire  = 1'b1;
                    state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_arr[idx], idx, 5'd0};
                bus.pmem_wdata   = data_arr[idx];
                if (bus.pmem_resp) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, idx, 5'd0};
                if (bus.pmem_resp) begin
                    fill_fire  = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            if (fill_fire) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (write_fire && (bus.mem_byte_enable != 4'd0)) begin
                dirty[idx] <= 1'b1;
            end
            // A flush on the same edge as an increment leaves the counter at zero.
            if (flush_hit) begin
                hit_count <= '0;
            end else if (hit_fire) begin
                hit_count <= hit_count + 32'd1;
            end
            if (flush_miss) begin
                miss_count <= '0;
            end else if (miss_fire) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && fill_fire) begin
            tag_arr[idx]  <= req_tag;
            data_arr[idx] <= bus.pmem_rdata;
        end else if (!rst && write_fire) begin
            data_arr[idx][word_lsb +: 32] <= merged_word;
        end
    end
endmodule
